alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared combinational 32-bit ALU (4-bit `ctrl`, operands `a`/`b`/`c`, result `d`). It accepts operation requests over valid/ready handshakes, holds the winning operands stable on the ALU inputs for one full cycle, and registers the result. It then returns the result with a requester ID over a valid/ready response channel. It sits between the ALU instance and its client blocks.

## Interface
- `WIDTH`, 32, operand/result width; must match the ALU.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request pending from requester 0 / 1.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle; combinational.
- `req0_ctrl` / `req1_ctrl`  in  4  ALU opcode.
- `req0_a`, `req0_b`, `req0_c` / `req1_a`, `req1_b`, `req1_c`  in  WIDTH  operands.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_d`  out  WIDTH  registered ALU result.
- `alu_ctrl`  out  4  drives the ALU `ctrl` input.
- `alu_a`, `alu_b`, `alu_c`  out  WIDTH  drive the ALU operand inputs.
- `alu_d`  in  WIDTH  ALU result.
- `busy`  out  1  high whenever state is not IDLE.
- `cnt0`, `cnt1`  out  16  completed-op counters; present only with `ALU_ARB_CNT_EN`.

## Operation
- FSM states: IDLE, EXEC, RESP. Encoding is free.
- **IDLE**
  - With no valid request, stay in IDLE.
  - Exactly one valid: grant it.
  - Both valid: grant the requester not in `last_gnt`.
  - On grant, assert that requester's `reqN_ready` in the same cycle.
  - At the clock edge, latch ctrl/a/b/c into operand registers, latch the grant into `id_q` and `last_gnt`, then go to EXEC.
- **EXEC**
  - Operand registers drive `alu_*`.
  - At the clock edge, latch `alu_d` into `rsp_d`, then go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_id`=`id_q`; `rsp_d` stays stable.
  - When `rsp_ready`=1, go to IDLE at that edge.
  - With `rsp_ready`=0, hold indefinitely; no new request is accepted.
- Both `reqN_ready` outputs are 0 outside IDLE. At most one `reqN_ready` is high in any cycle.
- `alu_*` outputs hold their last operands in IDLE and RESP; they are not cleared after use.
- Data path has no arithmetic; widths pass through unchanged.

## Timing
- Reset values:
  - state = IDLE; `last_gnt`=1 (so requester 0 wins the first tie).
  - `rsp_valid`=0, `rsp_id`=0, `rsp_d`=0, `busy`=0.
  - `alu_ctrl`=0, `alu_a`=`alu_b`=`alu_c`=0.
  - `cnt0`=`cnt1`=0.
- Latency: request accepted at edge N, so `rsp_valid` is high in cycle N+2 (rises after edge N+1).
- Peak throughput: one op per 3 cycles when `rsp_ready` is held at 1.
- A requester may drop `valid` before being granted; nothing is latched in that case.
- If `rsp_ready` is already high when RESP is entered, the response lasts exactly one cycle.
- `rst` asserted in any state, including mid-EXEC or mid-RESP, returns every register to its reset value at that edge. The in-flight op is discarded and no response is produced.
- `rst` has priority over any handshake in the same cycle.

## Configuration
- `ALU_ARB_CNT_EN` defined:
  - Adds `cnt0` and `cnt1`, one per requester.
  - The counter for `id_q` increments on each RESP-to-IDLE transition.
  - Counters saturate at 16'hFFFF and clear on `rst`.
- Not defined: ports, counters and their logic are absent; all other behaviour is identical.

## Test plan
Bench uses a behavioural ALU stub with `d = a + b + c`.
- Single request: after reset, req0 valid with ctrl=4'b0000, a=15, b=20, c=35, held. Expect `req0_ready` in cycle 0, then `rsp_valid`=1, `rsp_id`=0, `rsp_d`=70 in cycle 2.
- Tie and round-robin:
  - Both valid every cycle, `rsp_ready`=1, req0 a=1/b=0/c=0, req1 a=2/b=0/c=0.
  - Expect grants alternating 0,1,0,1 with `rsp_d` sequence 1,2,1,2.
  - Expect accepts every 3 cycles.
- Backpressure:
  - `rsp_ready`=0 for 10 cycles in RESP. `rsp_d`/`rsp_id` stay stable and both ready outputs stay 0; req1 stays pending.
  - Releasing `rsp_ready` returns to IDLE, and req1 is granted on the next cycle.
- Operand stability: req1 changes a=5 to a=9 in the cycle after its accept. Expect `alu_a`=5 throughout EXEC and `rsp_d` computed with a=5.
- Mid-operation reset: assert `rst` for one cycle during EXEC. Expect no `rsp_valid`, all outputs at reset values, and requester 0 winning the next tie.
- With `ALU_ARB_CNT_EN` defined:
  - Complete 3 req0 ops and 2 req1 ops. Expect `cnt0`=3, `cnt1`=2.
  - Force `cnt0` to 16'hFFFE, then complete 3 more req0 ops. Expect `cnt0`=16'hFFFF.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, response and ALU-side signal bundle for alu_arbiter
interface alu_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_ctrl;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req0_c;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_ctrl;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [WIDTH-1:0] req1_c;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_d;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_c;
  logic [WIDTH-1:0] alu_d;
  logic             busy;

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b, req0_c,
    output req1_valid, req1_ctrl, req1_a, req1_b, req1_c,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_d,
    output rsp_ready,
    input  alu_ctrl, alu_a, alu_b, alu_c,
    output alu_d,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b, req0_c,
    input  req1_valid, req1_ctrl, req1_a, req1_b, req1_c,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_d,
    input  rsp_ready,
    output alu_ctrl, alu_a, alu_b, alu_c,
    input  alu_d,
    output busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin sequencer for a shared combinational ALU
// Optional per-requester completion counters cnt0/cnt1 under ALU_ARB_CNT_EN.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_CNT_EN
  ,
  output logic [15:0]  cnt0,
  output logic [15:0]  cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_gnt;
  logic             id_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] d_q;
  logic             gnt_any;
  logic             gnt_id;

  // Reset wins over any handshake, so no grant is offered while rst is high.
  always_comb begin
    gnt_any = (state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_gnt;
    end else begin
      gnt_id = bus.req1_valid;
    end
  end

  assign bus.req0_ready = gnt_any && !gnt_id;
  assign bus.req1_ready = gnt_any && gnt_id;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_d      = d_q;
  assign bus.busy       = (state != IDLE);
  assign bus.alu_ctrl   = ctrl_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_c      = c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      id_q     <= 1'b0;
      ctrl_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
`ifdef ALU_ARB_CNT_EN
      cnt0     <= '0;
      cnt1     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            ctrl_q   <= gnt_id ? bus.req1_ctrl : bus.req0_ctrl;
            a_q      <= gnt_id ? bus.req1_a    : bus.req0_a;
            b_q      <= gnt_id ? bus.req1_b    : bus.req0_b;
            c_q      <= gnt_id ? bus.req1_c    : bus.req0_c;
            id_q     <= gnt_id;
            last_gnt <= gnt_id;
            state    <= EXEC;
          end
        end
        EXEC: begin
          d_q   <= bus.alu_d;
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
`ifdef ALU_ARB_CNT_EN
            if (!id_q && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (id_q && cnt1 != 16'hFFFF)  cnt1 <= cnt1 + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 0;

  alu_arbiter_if #(.WIDTH(32)) bus ();

`ifdef ALU_ARB_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  alu_arbiter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_ARB_CNT_EN
    ,
    .cnt0(cnt0),
    .cnt1(cnt1)
`endif
  );

  // ALU stub: d = a + b + c
  assign bus.alu_d = bus.alu_a + bus.alu_b + bus.alu_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one op in flight at a time, result due two
  // cycles after acceptance, retired when the consumer takes it.
  bit          m_inflight = 0;
  int          m_age      = 0;
  bit          m_last     = 1;
  bit          m_id       = 0;
  logic [31:0] m_d        = 0;
  logic [3:0]  m_ctrl     = 0;
  logic [31:0] m_a = 0, m_b = 0, m_c = 0;

  always @(negedge clk) begin
    bit m_offer;
    bit m_pick;
    m_offer = !m_inflight && !rst && (bus.req0_valid || bus.req1_valid);
    m_pick  = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
    if (mon_en) begin
      chk("m_req0_ready", bus.req0_ready, m_offer && !m_pick);
      chk("m_req1_ready", bus.req1_ready, m_offer && m_pick);
      chk("m_busy", bus.busy, m_inflight);
      chk("m_rsp_valid", bus.rsp_valid, m_inflight && m_age >= 2);
      chk("m_rsp_id", bus.rsp_id, m_id);
      chk("m_rsp_d", bus.rsp_d, m_d);
      chk("m_alu_ctrl", bus.alu_ctrl, m_ctrl);
      chk("m_alu_a", bus.alu_a, m_a);
      chk("m_alu_b", bus.alu_b, m_b);
      chk("m_alu_c", bus.alu_c, m_c);
    end
    if (rst) begin
      m_inflight = 0; m_age = 0; m_last = 1; m_id = 0; m_d = 0;
      m_ctrl = 0; m_a = 0; m_b = 0; m_c = 0;
    end else if (m_inflight) begin
      if (m_age == 1) begin
        m_d   = m_a + m_b + m_c;
        m_age = 2;
      end else if (bus.rsp_ready) begin
        m_inflight = 0;
      end
    end else if (m_offer) begin
      m_ctrl = m_pick ? bus.req1_ctrl : bus.req0_ctrl;
      m_a    = m_pick ? bus.req1_a : bus.req0_a;
      m_b    = m_pick ? bus.req1_b : bus.req0_b;
      m_c    = m_pick ? bus.req1_c : bus.req0_c;
      m_id   = m_pick;
      m_last = m_pick;
      m_inflight = 1;
      m_age  = 1;
    end
  end

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_ctrl = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_c = 0;
    bus.req1_valid = 0; bus.req1_ctrl = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_c = 0;
  endtask

  task automatic pulse_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

`ifdef ALU_ARB_CNT_EN
  task automatic do_op(input bit id);
    bit got;
    got = 0;
    bus.rsp_ready = 1;
    if (id) begin bus.req1_valid = 1; bus.req1_a = $urandom; end
    else    begin bus.req0_valid = 1; bus.req0_a = $urandom; end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = id ? bus.req1_ready : bus.req0_ready;
      step();
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    chk("op_accept", got, 1);
    repeat (3) step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          gnt_q[$];
    int          gcyc_q[$];
    logic [31:0] d_q[$];

    rst = 1;
    bus.rsp_ready = 0;
    idle_inputs();
    step();
    mon_en = 1;
    repeat (2) step();
    rst = 0;

    // Reset state
    @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rsp_d", bus.rsp_d, 0);
    chk("reset_rsp_id", bus.rsp_id, 0);
    chk("reset_alu_a", bus.alu_a, 0);
    chk("reset_alu_ctrl", bus.alu_ctrl, 0);
    step();

    // Single request
    bus.req0_valid = 1; bus.req0_ctrl = 4'b0000;
    bus.req0_a = 15; bus.req0_b = 20; bus.req0_c = 35;
    bus.rsp_ready = 1;
    @(negedge clk);
    chk("single_ready_c0", bus.req0_ready, 1);
    step();
    @(negedge clk);
    chk("single_valid_c1", bus.rsp_valid, 0);
    step();
    @(negedge clk);
    chk("single_valid_c2", bus.rsp_valid, 1);
    chk("single_id_c2", bus.rsp_id, 0);
    chk("single_d_c2", bus.rsp_d, 70);
    step();
    idle_inputs();
    step();

    // Tie and round-robin
    pulse_reset();
    bus.req0_valid = 1; bus.req0_a = 1;
    bus.req1_valid = 1; bus.req1_a = 2;
    bus.rsp_ready = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (bus.req0_ready) begin gnt_q.push_back(0); gcyc_q.push_back(cyc); end
      if (bus.req1_ready) begin gnt_q.push_back(1); gcyc_q.push_back(cyc); end
      if (bus.rsp_valid) d_q.push_back(bus.rsp_d);
      step();
    end
    idle_inputs();
    chk("rr_grant_count", gnt_q.size(), 4);
    chk("rr_rsp_count", d_q.size(), 4);
    for (int i = 0; i < gnt_q.size(); i++) begin
      chk("rr_grant_id", gnt_q[i], i % 2);
      chk("rr_grant_cycle", gcyc_q[i], 3 * i);
    end
    for (int i = 0; i < d_q.size(); i++) chk("rr_rsp_d", d_q[i], (i % 2) ? 2 : 1);
    repeat (2) step();

    // Backpressure with req1 pending, then operand stability for req1
    pulse_reset();
    bus.req0_valid = 1; bus.req0_a = 3; bus.req0_b = 4; bus.req0_c = 1;
    bus.rsp_ready = 0;
    @(negedge clk);
    chk("bp_req0_ready", bus.req0_ready, 1);
    step();
    bus.req0_valid = 0;
    bus.req1_valid = 1; bus.req1_a = 5; bus.req1_b = 1; bus.req1_c = 1;
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_d", bus.rsp_d, 8);
      chk("bp_rsp_id", bus.rsp_id, 0);
      chk("bp_ready_any", bus.req0_ready | bus.req1_ready, 0);
      step();
    end
    bus.rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_valid", bus.rsp_valid, 1);
    step();
    @(negedge clk);
    chk("bp_req1_granted", bus.req1_ready, 1);
    step();
    bus.req1_valid = 0;
    bus.req1_a = 9;
    @(negedge clk);
    chk("stab_alu_a", bus.alu_a, 5);
    step();
    @(negedge clk);
    chk("stab_rsp_id", bus.rsp_id, 1);
    chk("stab_rsp_d", bus.rsp_d, 7);
    step();
    idle_inputs();
    step();

    // Mid-operation reset
    bus.req0_valid = 1; bus.req0_a = 10;
    @(negedge clk);
    chk("mr_accept", bus.req0_ready, 1);
    step();
    bus.req0_valid = 0;
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_rsp_valid", bus.rsp_valid, 0);
      chk("mr_busy", bus.busy, 0);
      chk("mr_rsp_d", bus.rsp_d, 0);
      chk("mr_alu_a", bus.alu_a, 0);
      step();
    end
    bus.req0_valid = 1; bus.req1_valid = 1;
    @(negedge clk);
    chk("mr_tie_req0", bus.req0_ready, 1);
    chk("mr_tie_req1", bus.req1_ready, 0);
    step();
    idle_inputs();
    repeat (4) step();

`ifdef ALU_ARB_CNT_EN
    pulse_reset();
    repeat (3) do_op(0);
    repeat (2) do_op(1);
    chk("cnt0_three", cnt0, 3);
    chk("cnt1_two", cnt1, 2);
    force dut.cnt0 = 16'hFFFE;
    step();
    release dut.cnt0;
    repeat (3) do_op(0);
    chk("cnt0_saturate", cnt0, 16'hFFFF);
    chk("cnt1_unchanged", cnt1, 2);
`endif

    // Randomized traffic against the reference
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.req0_valid = ($urandom_range(0, 9) < 6);
      bus.req1_valid = ($urandom_range(0, 9) < 6);
      bus.req0_ctrl  = 4'($urandom);
      bus.req1_ctrl  = 4'($urandom);
      bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_c = $urandom_range(0, 255);
      bus.req1_a = $urandom; bus.req1_b = $urandom_range(0, 255); bus.req1_c = $urandom;
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0;
    idle_inputs();
    bus.rsp_ready = 1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
